// File: rtl/simon_pkg.sv
// Shared types and frame-length constants for the SIMON 32/64 feeder and drain blocks.
// Latency: none (package only).
// Backpressure: none (package only).
package simon_pkg;

  localparam int SIMON_N = 16;  // core word width
  localparam int SIMON_M = 4;   // key words
  localparam int SIMON_W = 8;   // stream byte width

  localparam int KEY_BYTES = SIMON_M * SIMON_N / SIMON_W;
  localparam int BLK_BYTES = 2 * SIMON_N / SIMON_W;

  typedef enum logic [2:0] {
    S_COLLECT,
    S_KEY_REQ,
    S_KEY_BUSY,
    S_DATA_REQ,
    S_DATA_BUSY
  } state_t;

endpackage

// File: rtl/simon_3264_loader_if.sv
// Byte-wide valid/ready stream feeding the SIMON loader.
// Latency: wires only.
// Backpressure: in_ready from the slave qualifies every in_valid byte.
interface simon_3264_loader_if
  import simon_pkg::*;
#(
  parameter int W = SIMON_W
);
  logic [W-1:0] in_data;
  logic         in_is_key;
  logic         in_dec;
  logic         in_valid;
  logic         in_ready;

  modport master (output in_data, in_is_key, in_dec, in_valid, input in_ready);
  modport slave  (input in_data, in_is_key, in_dec, in_valid, output in_ready);
endinterface

// File: rtl/simon_byte_shifter.sv
// Shift register that takes one byte per enable from the LSB side, oldest byte ends on top.
// Latency: one cycle from shift_en to updated q.
// Backpressure: none; shifts whenever shift_en is high.
module simon_byte_shifter #(
  parameter int WIDTH = 64,
  parameter int W     = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             shift_en,
  input  logic [W-1:0]     din,
  output logic [WIDTH-1:0] q
);

  // Synchronous clear has priority over shifting.
  always_ff @(posedge clk) begin
    if (clr) q <= '0;
    else if (shift_en) q <= {q[WIDTH-W-1:0], din};
  end

endmodule

// File: rtl/simon_3264_loader.sv
// Assembles byte stream into SIMON 32/64 key/data frames and hands them to the core.
// Latency: strobe earliest one cycle after the last byte; next byte the cycle after done.
// Backpressure: in_ready only in S_COLLECT; REQ/BUSY wait indefinitely on core handshakes.
module simon_3264_loader
  import simon_pkg::*;
#(
  parameter int N  = SIMON_N,
  parameter int M  = SIMON_M,
  parameter int W  = SIMON_W,
  parameter int CW = 3
) (
  input  logic                   clk,
  input  logic                   nR,
  simon_3264_loader_if.slave     strm,
  input  logic                   loadKey,
  input  logic                   doneKey,
  input  logic                   loadData,
  input  logic                   doneData,
  output logic [M-1:0][N-1:0]    KEY,
  output logic [1:0][N-1:0]      blockIN,
  output logic                   enc_dec,
  output logic                   newKey,
  output logic                   newData,
  output logic                   key_valid,
  output logic                   err,
  output logic                   busy
);

  localparam logic [CW-1:0] KEY_LAST = CW'(M * N / W - 1);
  localparam logic [CW-1:0] BLK_LAST = CW'(2 * N / W - 1);

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic            is_key_q, dec_q;
  logic            in_rdy;
  logic            accept, first, cur_key, cur_dec, last_byte;
  logic            key_last, data_last;
  logic [M*N-1:0]  key_q;
  // The data shadow only keeps the bytes before the last one; the last byte is
  // concatenated straight from the stream when the frame is committed to blockIN.
  logic [2*N-W-1:0] shadow_q;

  assign accept    = strm.in_valid && in_rdy;
  assign first     = (cnt == '0);
  assign cur_key   = first ? strm.in_is_key : is_key_q;
  assign cur_dec   = first ? strm.in_dec : dec_q;
  assign last_byte = accept && (cnt == (cur_key ? KEY_LAST : BLK_LAST));
  assign key_last  = last_byte && cur_key;
  assign data_last = last_byte && !cur_key;

  assign strm.in_ready = in_rdy;
  assign KEY           = key_q;

  // State register.
  always_ff @(posedge clk) begin
    if (nR) state <= S_COLLECT;
    else    state <= state_nxt;
  end

  // Next-state decode; a done seen in a REQ state is ignored because it is not BUSY yet.
  always_comb begin
    state_nxt = state;
    case (state)
      S_COLLECT: begin
        if (key_last)                    state_nxt = S_KEY_REQ;
        else if (data_last && key_valid) state_nxt = S_DATA_REQ;
      end
      S_KEY_REQ:   if (loadKey)  state_nxt = S_KEY_BUSY;
      S_KEY_BUSY:  if (doneKey)  state_nxt = S_COLLECT;
      S_DATA_REQ:  if (loadData) state_nxt = S_DATA_BUSY;
      S_DATA_BUSY: if (doneData) state_nxt = S_COLLECT;
      default:                   state_nxt = S_COLLECT;
    endcase
  end

  // Moore-gated strobes and status; each strobe leaves REQ on the same edge, so it lasts one cycle.
  always_comb begin
    in_rdy  = (state == S_COLLECT);
    newKey  = (state == S_KEY_REQ) && loadKey;
    newData = (state == S_DATA_REQ) && loadData;
    busy    = (state != S_COLLECT);
  end

  // Byte counter and first-byte frame-type latch.
  always_ff @(posedge clk) begin
    if (nR) begin
      cnt      <= '0;
      is_key_q <= 1'b0;
      dec_q    <= 1'b0;
    end else if (accept) begin
      cnt <= last_byte ? '0 : cnt + CW'(1);
      if (first) begin
        is_key_q <= strm.in_is_key;
        dec_q    <= strm.in_dec;
      end
    end
  end

  // Frame commit, key_valid tracking and the dropped-frame error pulse.
  always_ff @(posedge clk) begin
    if (nR) begin
      blockIN   <= '0;
      enc_dec   <= 1'b0;
      key_valid <= 1'b0;
      err       <= 1'b0;
    end else begin
      err <= data_last && !key_valid;
      if (key_last)                                key_valid <= 1'b0;
      else if ((state == S_KEY_BUSY) && doneKey)   key_valid <= 1'b1;
      if (data_last && key_valid) begin
        blockIN <= {shadow_q, strm.in_data};
        enc_dec <= cur_dec;
      end
    end
  end

  simon_byte_shifter #(.WIDTH(M*N), .W(W)) u_key_shift (
    .clk      (clk),
    .clr      (nR),
    .shift_en (accept && cur_key),
    .din      (strm.in_data),
    .q        (key_q)
  );

  simon_byte_shifter #(.WIDTH(2*N-W), .W(W)) u_data_shadow (
    .clk      (clk),
    .clr      (nR),
    .shift_en (accept && !cur_key),
    .din      (strm.in_data),
    .q        (shadow_q)
  );

endmodule

// File: tb/tb_simon_3264_loader.sv
// Directed bench for the SIMON 32/64 loader with hand-computed expectations.
// Latency: inputs driven on negedge, outputs sampled 1 time unit later.
// Backpressure: core handshakes driven directly from the stimulus sequence.
module tb_simon_3264_loader;
  import simon_pkg::*;

  logic clk = 1'b0;
  logic nR;
  logic loadKey, doneKey, loadData, doneData;
  logic [3:0][15:0] KEY;
  logic [1:0][15:0] blockIN;
  logic enc_dec, newKey, newData, key_valid, err, busy;

  int nvec = 0;
  int nmis = 0;
  int n_nk = 0;
  int n_nd = 0;
  int n_err = 0;

  simon_3264_loader_if #(.W(8)) bus ();

  simon_3264_loader dut (
    .clk       (clk),
    .nR        (nR),
    .strm      (bus),
    .loadKey   (loadKey),
    .doneKey   (doneKey),
    .loadData  (loadData),
    .doneData  (doneData),
    .KEY       (KEY),
    .blockIN   (blockIN),
    .enc_dec   (enc_dec),
    .newKey    (newKey),
    .newData   (newData),
    .key_valid (key_valid),
    .err       (err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Strobe/pulse counters sampled on the active edge.
  always @(posedge clk) begin
    n_nk  <= n_nk + int'(newKey);
    n_nd  <= n_nd + int'(newData);
    n_err <= n_err + int'(err);
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %h, want %h", tag, got, exp);
    end
  endtask

  // {newKey, newData, err, busy, key_valid, enc_dec, in_ready}
  function automatic logic [63:0] flags();
    return 64'({newKey, newData, err, busy, key_valid, enc_dec, bus.in_ready});
  endfunction

  // Sends n bytes MSB first; ends on the negedge after the last accepting edge with in_valid low.
  task automatic send_frame(input logic [63:0] v, input int n, input logic k, input logic d,
                            input logic tog);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bus.in_valid = 1'b1;
      bus.in_data  = v[8*(n-1-i) +: 8];
      if (i == 0) begin
        bus.in_is_key = k;
        bus.in_dec    = d;
      end else if (tog) begin
        bus.in_is_key = ~bus.in_is_key;
        bus.in_dec    = ~bus.in_dec;
      end
      #1;
      chk("byte_ready", 64'(bus.in_ready), 64'h1);
      @(posedge clk);
    end
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.in_is_key = 1'b0;
    bus.in_dec    = 1'b0;
  endtask

  logic [7:0] bb [12];
  int idx, nk_j, dk_j, lk_j, d0_j, nk0, nd0, err0;
  logic acc;

  initial begin
    nR = 1'b1;
    loadKey = 1'b0; doneKey = 1'b0; loadData = 1'b0; doneData = 1'b0;
    bus.in_valid = 1'b0; bus.in_data = '0; bus.in_is_key = 1'b0; bus.in_dec = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_flags", flags(), 64'b0000001);
    chk("rst_key",   64'(KEY), 64'h0);
    chk("rst_blk",   64'(blockIN), 64'h0);
    @(negedge clk);
    nR = 1'b0;
    loadKey = 1'b1;

    // Data frame before any key: dropped with one err pulse
    err0 = n_err; nd0 = n_nd;
    send_frame(64'h65656877, BLK_BYTES, 1'b0, 1'b0, 1'b0);
    #1;
    chk("nokey_err",  flags(), 64'b0010001);
    chk("nokey_blk",  64'(blockIN), 64'h0);
    @(negedge clk); #1;
    chk("nokey_after", flags(), 64'b0000001);
    chk("nokey_nerr", 64'(n_err - err0), 64'd1);
    chk("nokey_nnd",  64'(n_nd - nd0), 64'd0);

    // Key load, doneKey three cycles after newKey
    nk0 = n_nk;
    send_frame(64'h1918111009080100, KEY_BYTES, 1'b1, 1'b0, 1'b0);
    #1;
    chk("key_strobe", flags(), 64'b1001000);
    chk("key_val",    64'(KEY), 64'h1918111009080100);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); #1;
      chk("key_busy", flags(), 64'b0001000);
    end
    @(negedge clk); doneKey = 1'b1; #1;
    chk("key_done_cyc", flags(), 64'b0001000);
    @(negedge clk); doneKey = 1'b0; #1;
    chk("key_loaded", flags(), 64'b0000101);
    chk("key_nstrobe", 64'(n_nk - nk0), 64'd1);

    // Encrypt frame, loadData held low five cycles, bytes offered while not ready
    loadData = 1'b0;
    nd0 = n_nd;
    send_frame(64'h65656877, BLK_BYTES, 1'b0, 1'b0, 1'b0);
    bus.in_valid = 1'b1; bus.in_data = 8'hAA; bus.in_is_key = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("enc_wait", flags(), 64'b0001100);
      @(negedge clk);
    end
    bus.in_valid = 1'b0; bus.in_is_key = 1'b0;
    loadData = 1'b1; doneData = 1'b1; #1;
    chk("enc_strobe", flags(), 64'b0101100);
    chk("enc_blk",    64'(blockIN), 64'h65656877);
    @(negedge clk); doneData = 1'b0; #1;
    chk("enc_done_ign", flags(), 64'b0001100);
    @(negedge clk); doneData = 1'b1; #1;
    chk("enc_busy", flags(), 64'b0001100);
    @(negedge clk); doneData = 1'b0; #1;
    chk("enc_back", flags(), 64'b0000101);
    chk("enc_blk_hold", 64'(blockIN), 64'h65656877);
    chk("enc_key_hold", 64'(KEY), 64'h1918111009080100);
    chk("enc_nstrobe", 64'(n_nd - nd0), 64'd1);

    // Frame-type latch: flags toggled on non-first bytes
    send_frame(64'hA1B2C3D4, BLK_BYTES, 1'b0, 1'b1, 1'b1);
    #1;
    chk("ftl_strobe", flags(), 64'b0101110);
    chk("ftl_blk",    64'(blockIN), 64'hA1B2C3D4);
    chk("ftl_key",    64'(KEY), 64'h1918111009080100);
    @(negedge clk); doneData = 1'b1;
    @(negedge clk); doneData = 1'b0; #1;
    chk("ftl_back", flags(), 64'b0000111);

    // Reset in S_DATA_BUSY, then a stray doneData
    nk0 = n_nk; nd0 = n_nd;
    send_frame(64'h11223344, BLK_BYTES, 1'b0, 1'b1, 1'b0);
    #1;
    chk("rmh_strobe", flags(), 64'b0101110);
    @(negedge clk); #1;
    chk("rmh_busy", flags(), 64'b0001110);
    nR = 1'b1;
    @(negedge clk); nR = 1'b0; #1;
    chk("rmh_flags", flags(), 64'b0000001);
    chk("rmh_key",   64'(KEY), 64'h0);
    chk("rmh_blk",   64'(blockIN), 64'h0);
    @(negedge clk); doneData = 1'b1; #1;
    chk("rmh_stray", flags(), 64'b0000001);
    @(negedge clk); doneData = 1'b0; #1;
    chk("rmh_idle", flags(), 64'b0000001);
    chk("rmh_nk", 64'(n_nk - nk0), 64'd0);
    chk("rmh_nd", 64'(n_nd - nd0), 64'd1);

    // Back-to-back key then data with in_valid held high
    bb = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'hAB, 8'hCD, 8'hEF,
           8'hDE, 8'hAD, 8'hBE, 8'hEF};
    idx = 0; nk_j = -100; dk_j = -100; lk_j = -100; d0_j = -100;
    for (int j = 0; j < 60 && idx < 12; j++) begin
      @(negedge clk);
      bus.in_valid  = 1'b1;
      bus.in_data   = bb[idx];
      bus.in_is_key = (idx < KEY_BYTES);
      bus.in_dec    = 1'b0;
      doneKey       = (j == nk_j + 1);
      #1;
      if (newKey)  nk_j = j;
      if (doneKey) dk_j = j;
      acc = bus.in_ready;
      @(posedge clk);
      if (acc) begin
        if (idx == KEY_BYTES - 1) lk_j = j;
        if (idx == KEY_BYTES)     d0_j = j;
        idx++;
      end
    end
    chk("b2b_all_bytes", 64'(idx), 64'd12);
    chk("b2b_nk_lat",    64'(nk_j - lk_j), 64'd1);
    chk("b2b_d0_lat",    64'(d0_j - dk_j), 64'd1);
    @(negedge clk);
    bus.in_valid = 1'b0; doneKey = 1'b0; #1;
    chk("b2b_strobe", flags(), 64'b0101100);
    chk("b2b_key",    64'(KEY), 64'h0123456789ABCDEF);
    chk("b2b_blk",    64'(blockIN), 64'hDEADBEEF);
    @(negedge clk); doneData = 1'b1;
    @(negedge clk); doneData = 1'b0; #1;
    chk("b2b_back", flags(), 64'b0000101);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/simon_3264_loader.md
Name: simon_3264_loader

Overview:
Upstream feeder for the SIMON 32/64 core. It accepts a byte-wide valid/ready stream and assembles 64-bit key frames and 32-bit data frames. It then hands each frame to the core through the core's newKey/loadKey/doneKey and newData/loadData/doneData handshakes. It blocks encryption/decryption requests until a key has been loaded, and flags data frames that arrive without a loaded key.

Parameters:
N, 16, core word width in bits
M, 4, key words
W, 8, input byte width; 2N and M*N must be multiples of W
CW, 3, byte-counter width; at least clog2(M*N/W)

Ports:
clk  in  1  clock
nR  in  1  synchronous reset, active-high (1 = reset)
in_data  in  W  stream byte, most-significant byte first
in_is_key  in  1  frame type, sampled on first byte of a frame
in_dec  in  1  1 = decrypt, sampled on first byte of a data frame
in_valid  in  1  byte present
in_ready  out  1  loader accepts byte this cycle
loadKey  in  1  core can take a key
doneKey  in  1  core key expansion finished
loadData  in  1  core can take a block
doneData  in  1  core finished the block
KEY  out  [M-1:0][N-1:0]  key to core; KEY[M-1] holds the first bytes
blockIN  out  [1:0][N-1:0]  block to core; blockIN[1] holds the first bytes
enc_dec  out  1  latched in_dec of the current data frame
newKey  out  1  one-cycle key strobe
newData  out  1  one-cycle data strobe
key_valid  out  1  a key has completed expansion since reset
err  out  1  one-cycle pulse: data frame dropped, no key loaded
busy  out  1  state other than S_COLLECT

Behaviour:
- Reset (nR=1 at edge):
  - State goes to S_COLLECT; byte counter and frame-type latch clear.
  - KEY, blockIN, enc_dec = 0; key_valid = 0.
  - newKey, newData, err, busy = 0.
  - Reset mid-handshake abandons the frame; no strobe follows reset.
- Byte accept: a byte is taken when in_valid && in_ready at the clock edge. in_ready = (state == S_COLLECT).
- Frame assembly:
  - First byte of a frame latches in_is_key (and in_dec).
  - Each byte shifts into the target register from the LSB side: reg <= {reg, in_data}. After the last byte, the first byte sits in the top bits.
  - Frame length is M*N/W bytes for a key (8) and 2N/W bytes for data (4). The counter wraps to 0 on the last byte.
  - in_is_key and in_dec on non-first bytes are ignored.
- States:
  - S_COLLECT:
    - Last key byte accepted -> S_KEY_REQ; key_valid <= 0 on the same edge.
    - Last data byte with key_valid=1 -> S_DATA_REQ.
    - Last data byte with key_valid=0 -> err=1 for the following cycle; stay in S_COLLECT; blockIN is left unchanged (shift goes to a shadow register, copied to blockIN only when the frame is accepted).
  - S_KEY_REQ: newKey = loadKey (combinational, Moore-gated). The first cycle with loadKey=1 moves to S_KEY_BUSY.
  - S_KEY_BUSY: waits for doneKey=1 -> key_valid <= 1, -> S_COLLECT.
  - S_DATA_REQ: newData = loadData. The first cycle with loadData=1 moves to S_DATA_BUSY.
  - S_DATA_BUSY: waits for doneData=1 -> S_COLLECT.
- Stability: KEY, blockIN and enc_dec are held constant from entry to S_x_REQ until the return to S_COLLECT.
- Latency: last byte accepted at edge t; newKey/newData can be high in cycle t+1 at the earliest. The next byte is accepted in the cycle after doneX is sampled.
- Strobe rules:
  - Each strobe is high for exactly one cycle per frame.
  - doneKey/doneData are ignored outside their BUSY state.
  - A doneX that coincides with the strobe cycle is ignored; BUSY requires a done in a later cycle.
- No timeouts; the loader waits indefinitely in REQ or BUSY.

Decomposition:
- Package simon_pkg: state enum typedef (S_COLLECT, S_KEY_REQ, S_KEY_BUSY, S_DATA_REQ, S_DATA_BUSY) and the frame-length constants KEY_BYTES = M*N/W and BLK_BYTES = 2N/W. Shared with the planned output-side drain block.
- One sub-module, simon_byte_shifter (parameterised width, shift-in, clear), instantiated twice: once for the key, once for the data shadow.

Test Plan:
- Key load:
  - Stimulus: stream 19 18 11 10 09 08 01 00 with in_is_key=1; hold loadKey=1; doneKey 3 cycles after newKey.
  - Required: KEY = {1918,1110,0908,0100}; newKey is a single pulse in the cycle after the last byte; key_valid=1 after doneKey; in_ready=0 throughout.
- Data before key:
  - Stimulus: after reset, stream 65 65 68 77 with in_is_key=0.
  - Required: one err pulse; newData never asserted; blockIN stays 0; in_ready returns to 1 immediately.
- Encrypt frame:
  - Stimulus: after the key load, stream 65 65 68 77 with in_dec=0; loadData low for 5 cycles, then high.
  - Required: newData asserts only in the first cycle with loadData=1; blockIN = {6565,6877}; enc_dec=0; bytes sent during BUSY are not accepted.
- Frame-type latch:
  - Stimulus: data frame with in_dec=1 on byte 0 and in_is_key/in_dec toggled on bytes 1-3.
  - Required: treated as a data frame; enc_dec=1.
- Reset mid-handshake:
  - Stimulus: assert nR in S_DATA_BUSY; deassert it; later pulse doneData.
  - Required: all outputs 0 after the edge; key_valid=0; no strobe; the stray doneData is ignored.
- Back-to-back frames:
  - Stimulus: key, then data immediately after doneKey; in_valid held high continuously.
  - Required: first data byte accepted in the cycle after doneKey is sampled; correct byte count across the counter wrap.
